multicycle_ctrl: RTL and testbench



---
 rtl/multicycle_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl -- main controller of the multicycle MIPS core.
//
// A Moore FSM steps the shared datapath through fetch, decode, execute,
// memory and writeback.  The datapath controls are registered alongside the
// state, so each one is a pure decode of the current state.  The exceptions
// are pcen, which also depends on the live zero flag, and alucontrol, which
// is decoded from the registered aluop and the live funct field.
//
// Optional build macro: MULTICYCLE_BNE_EN
//   defined   -> op 000101 (bne) runs through BNEEX; the PC branches when zero=0
//   undefined -> op 000101 is treated as an undefined opcode
//
// Ports:
//   clk, reset             clock; asynchronous active-high reset
//   op, funct              instruction fields from the IR
//   zero                   ALU zero flag for the current cycle
//   pcen, irwrite          PC and IR register enables
//   memwrite, regwrite     memory write strobe, register-file write enable
//   iord                   memory address select (0=PC, 1=ALUOut)
//   memtoreg, regdst       writeback data / destination register selects
//   alusrca, alusrcb       ALU operand selects
//   pcsrc                  next-PC select (00=ALUResult, 01=ALUOut, 10=jump)
//   extsel                 immediate extension (0=sign, 1=zero)
//   alucontrol             ALU operation
//   state                  current FSM state (debug)
module multicycle_ctrl #(
    parameter int unsigned STATE_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         op,
    input  logic [5:0]         funct,
    input  logic               zero,
    output logic               pcen,
    output logic               irwrite,
    output logic               memwrite,
    output logic               regwrite,
    output logic               iord,
    output logic               memtoreg,
    output logic               regdst,
    output logic               alusrca,
    output logic [1:0]         alusrcb,
    output logic [1:0]         pcsrc,
    output logic               extsel,
    output logic [2:0]         alucontrol,
    output logic [STATE_W-1:0] state
);

    typedef enum logic [STATE_W-1:0] {
        FETCH   = STATE_W'(0),
        DECODE  = STATE_W'(1),
        MEMADR  = STATE_W'(2),
        MEMRD   = STATE_W'(3),
        MEMWB   = STATE_W'(4),
        MEMWR   = STATE_W'(5),
        RTYPEEX = STATE_W'(6),
        RTYPEWB = STATE_W'(7),
        BEQEX   = STATE_W'(8),
        ADDIEX  = STATE_W'(9),
        ADDIWB  = STATE_W'(10),
        JEX     = STATE_W'(11),
        ORIEX   = STATE_W'(12),
        BNEEX   = STATE_W'(13)
    } state_t;

    typedef struct packed {
        logic       pcwrite;
        logic       branch;
        logic       branchne;
        logic       irwrite;
        logic       memwrite;
        logic       regwrite;
        logic       iord;
        logic       memtoreg;
        logic       regdst;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic       extsel;
        logic [1:0] aluop;
    } ctl_t;

    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_RTYP = 6'b000000;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ORI  = 6'b001101;
`ifdef MULTICYCLE_BNE_EN
    localparam logic [5:0] OP_BNE  = 6'b000101;
`endif

    state_t st;
    state_t nxt;
    ctl_t   c;

    function automatic ctl_t decode(input state_t s);
        ctl_t d;
        d = '0;
        case (s)
            FETCH:   begin d.irwrite = 1'b1; d.pcwrite = 1'b1; d.alusrcb = 2'b01; end
            DECODE:  d.alusrcb = 2'b11;
            MEMADR:  begin d.alusrca = 1'b1; d.alusrcb = 2'b10; end
            MEMRD:   d.iord = 1'b1;
            MEMWB:   begin d.regwrite = 1'b1; d.memtoreg = 1'b1; end
            MEMWR:   begin d.iord = 1'b1; d.memwrite = 1'b1; end
            RTYPEEX: begin d.alusrca = 1'b1; d.aluop = 2'b10; end
            RTYPEWB: begin d.regwrite = 1'b1; d.regdst = 1'b1; end
            BEQEX:   begin
                d.alusrca = 1'b1; d.aluop = 2'b01; d.pcsrc = 2'b01; d.branch = 1'b1;
            end
            ADDIEX:  begin d.alusrca = 1'b1; d.alusrcb = 2'b10; end
            ADDIWB:  d.regwrite = 1'b1;
            JEX:     begin d.pcsrc = 2'b10; d.pcwrite = 1'b1; end
            ORIEX:   begin
                d.alusrca = 1'b1; d.alusrcb = 2'b10; d.extsel = 1'b1; d.aluop = 2'b11;
            end
`ifdef MULTICYCLE_BNE_EN
            BNEEX:   begin
                d.alusrca = 1'b1; d.aluop = 2'b01; d.pcsrc = 2'b01; d.branchne = 1'b1;
            end
`endif
            default: d = '0;
        endcase
        return d;
    endfunction

    always_comb begin
        nxt = FETCH;
        case (st)
            FETCH:   nxt = DECODE;
            DECODE:  begin
                case (op)
                    OP_LW, OP_SW: nxt = MEMADR;
                    OP_RTYP:      nxt = RTYPEEX;
                    OP_BEQ:       nxt = BEQEX;
                    OP_ADDI:      nxt = ADDIEX;
                    OP_J:         nxt = JEX;
                    OP_ORI:       nxt = ORIEX;
`ifdef MULTICYCLE_BNE_EN
                    OP_BNE:       nxt = BNEEX;
`endif
                    default:      nxt = FETCH;
                endcase
            end
            MEMADR:  nxt = (op == OP_SW) ? MEMWR : MEMRD;
            MEMRD:   nxt = MEMWB;
            RTYPEEX: nxt = RTYPEWB;
            ADDIEX:  nxt = ADDIWB;
            ORIEX:   nxt = ADDIWB;
            default: nxt = FETCH;
        endcase
    end

    // Controls are registered from the decode of the next state, so they
    // always equal decode(st) without a combinational path from st.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st <= FETCH;
            c  <= decode(FETCH);
        end else begin
            st <= nxt;
            c  <= decode(nxt);
        end
    end

    always_comb begin
        alucontrol = 3'b010;
        case (c.aluop)
            2'b00: alucontrol = 3'b010;
            2'b01: alucontrol = 3'b110;
            2'b11: alucontrol = 3'b001;
            default: begin
                case (funct)
                    6'b100000: alucontrol = 3'b010;
                    6'b100010: alucontrol = 3'b110;
                    6'b100100: alucontrol = 3'b000;
                    6'b100101: alucontrol = 3'b001;
                    6'b101010: alucontrol = 3'b111;
                    default:   alucontrol = 3'b000;
                endcase
            end
        endcase
    end

    assign pcen     = c.pcwrite | (c.branch & zero) | (c.branchne & ~zero);
    assign irwrite  = c.irwrite;
    assign memwrite = c.memwrite;
    assign regwrite = c.regwrite;
    assign iord     = c.iord;
    assign memtoreg = c.memtoreg;
    assign regdst   = c.regdst;
    assign alusrca  = c.alusrca;
    assign alusrcb  = c.alusrcb;
    assign pcsrc    = c.pcsrc;
    assign extsel   = c.extsel;
    assign state    = st;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl -- self-checking bench for multicycle_ctrl.
// Expected state sequences come from per-instruction paths; expected
// controls are derived signal by signal from the state being visited.
module tb_multicycle_ctrl;

    localparam int unsigned STATE_W = 4;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic [5:0]         op = '0;
    logic [5:0]         funct = '0;
    logic               zero = 1'b0;
    logic               pcen, irwrite, memwrite, regwrite, iord, memtoreg, regdst, alusrca;
    logic [1:0]         alusrcb, pcsrc;
    logic               extsel;
    logic [2:0]         alucontrol;
    logic [STATE_W-1:0] state;

    int unsigned checks = 0;
    int unsigned fails  = 0;

`ifdef MULTICYCLE_BNE_EN
    localparam bit BNE_EN = 1'b1;
`else
    localparam bit BNE_EN = 1'b0;
`endif

    multicycle_ctrl #(.STATE_W(STATE_W)) dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .pcen(pcen), .irwrite(irwrite), .memwrite(memwrite), .regwrite(regwrite),
        .iord(iord), .memtoreg(memtoreg), .regdst(regdst), .alusrca(alusrca),
        .alusrcb(alusrcb), .pcsrc(pcsrc), .extsel(extsel), .alucontrol(alucontrol),
        .state(state)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    typedef int unsigned path_t [6];

    // State sequence of one instruction, starting at FETCH.
    function automatic void get_path(input logic [5:0] o, output path_t p, output int unsigned n);
        p = '{default: 0};
        p[1] = 1;
        case (o)
            6'b100011: begin p[2] = 2;  p[3] = 3;  p[4] = 4; n = 5; end
            6'b101011: begin p[2] = 2;  p[3] = 5;  n = 4; end
            6'b000000: begin p[2] = 6;  p[3] = 7;  n = 4; end
            6'b000100: begin p[2] = 8;  n = 3; end
            6'b001000: begin p[2] = 9;  p[3] = 10; n = 4; end
            6'b000010: begin p[2] = 11; n = 3; end
            6'b001101: begin p[2] = 12; p[3] = 10; n = 4; end
            6'b000101: begin
                if (BNE_EN) begin p[2] = 13; n = 3; end
                else n = 2;
            end
            default:   n = 2;
        endcase
    endfunction

    function automatic logic [2:0] rtype_alu(input logic [5:0] f);
        case (f)
            6'b100000: return 3'b010;
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b000;
        endcase
    endfunction

    // {pcen,irwrite,memwrite,regwrite,iord,memtoreg,regdst,alusrca,alusrcb,pcsrc,extsel,alucontrol}
    function automatic logic [17:0] exp_ctl(input int unsigned s, input logic [5:0] f, input logic z);
        logic       e_pcen;
        logic [1:0] e_srcb, e_pcsrc;
        logic [2:0] e_alu;
        e_pcen  = (s == 0) || (s == 11) || (s == 8 && z) || (s == 13 && !z);
        e_srcb  = (s == 0) ? 2'b01 : (s == 1) ? 2'b11 : (s inside {2, 9, 12}) ? 2'b10 : 2'b00;
        e_pcsrc = (s inside {8, 13}) ? 2'b01 : (s == 11) ? 2'b10 : 2'b00;
        e_alu   = (s inside {8, 13}) ? 3'b110 : (s == 12) ? 3'b001 :
                  (s == 6) ? rtype_alu(f) : 3'b010;
        return {e_pcen, s == 0, s == 5, s inside {4, 7, 10}, s inside {3, 5}, s == 4, s == 7,
                s inside {2, 6, 8, 9, 12, 13}, e_srcb, e_pcsrc, s == 12, e_alu};
    endfunction

    function automatic logic [17:0] got_ctl();
        return {pcen, irwrite, memwrite, regwrite, iord, memtoreg, regdst, alusrca,
                alusrcb, pcsrc, extsel, alucontrol};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // zsel: 0/1 forces zero, 2 randomises it every cycle.
    task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input int unsigned zsel);
        path_t       p;
        int unsigned n;
        get_path(o, p, n);
        op = o;
        funct = f;
        for (int unsigned k = 0; k < n; k++) begin
            zero = (zsel == 2) ? 1'($urandom_range(0, 1)) : 1'(zsel);
            #1;
            check($sformatf("state op=%b step%0d", o, k), 32'(state), p[k]);
            check($sformatf("ctl op=%b st=%0d z=%b", o, p[k], zero), 32'(got_ctl()),
                  32'(exp_ctl(p[k], f, zero)));
            @(posedge clk);
            #1;
        end
    endtask

    logic [5:0] ops [10];

    initial begin
        ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000,
                6'b000010, 6'b001101, 6'b000101, 6'b111111, 6'b000000};

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check("reset state", 32'(state), 0);
        check("reset ctl", 32'(got_ctl()), 32'(exp_ctl(0, funct, zero)));
        @(negedge clk);
        reset = 1'b0;

        // Directed instructions.
        run_instr(6'b100011, 6'b000000, 2);
        run_instr(6'b000000, 6'b101010, 2);
        run_instr(6'b000000, 6'b000111, 2);
        run_instr(6'b000100, 6'b000000, 1);
        run_instr(6'b000100, 6'b000000, 0);
        run_instr(6'b001101, 6'b000000, 2);
        run_instr(6'b111111, 6'b000000, 2);
        run_instr(6'b000101, 6'b000000, 0);
        run_instr(6'b000101, 6'b000000, 1);
        run_instr(6'b101011, 6'b000000, 2);
        run_instr(6'b000010, 6'b000000, 2);
        run_instr(6'b001000, 6'b000000, 2);

        // Reset in the middle of a load, while in MEMRD.
        op = 6'b100011;
        zero = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("pre-reset memrd", 32'(state), 3);
        #1;
        reset = 1'b1;
        #1;
        check("async reset state", 32'(state), 0);
        check("async reset irwrite", 32'(irwrite), 1);
        check("async reset alucontrol", 32'(alucontrol), 32'(3'b010));
        check("async reset ctl", 32'(got_ctl()), 32'(exp_ctl(0, funct, zero)));
        @(negedge clk);
        reset = 1'b0;
        op = 6'b111111;
        @(posedge clk);
        #1;
        check("post-reset decode", 32'(state), 1);
        check("post-reset ctl", 32'(got_ctl()), 32'(exp_ctl(1, funct, zero)));
        @(posedge clk);
        #1;
        check("post-reset back to fetch", 32'(state), 0);

        // Randomised instruction stream.
        for (int i = 0; i < 150; i++) begin
            logic [5:0] o;
            logic [5:0] f;
            int unsigned sel;
            sel = $urandom_range(0, 10);
            o = (sel == 10) ? 6'($urandom) : ops[sel];
            f = ($urandom_range(0, 1) == 1) ? 6'($urandom) :
                (sel % 2 == 0) ? 6'b100000 | 6'($urandom_range(0, 10) & 6'h0f) : 6'b101010;
            run_instr(o, f, 2);
        end

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
